// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle between the CPU stages, the arbiter and the shared memory port.
// The arbiter uses the slave view. The environment (CPU stages, memory model or
// testbench) uses the master view.
interface cpu_mem_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Shares one sram-like memory port between the instruction fetch requester and
// the data requester. Only one transaction is outstanding at a time. The
// response is routed back to whichever side owns that transaction.
//
// state | meaning
// IDLE  | no transaction outstanding; the granted side is presented to memory
// WAIT  | address accepted; waiting for mem_data_ok for the current owner
//
// The request and response paths are combinational so that the arbiter adds no
// latency in either direction. Only the state, owner and last_grant are registered.
module cpu_mem_arbiter #(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  cpu_mem_arbiter_if.slave         bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state;
  logic   owner;       // 0 = inst, 1 = data
  logic   last_grant;  // 0 = inst, 1 = data
  logic   grant_data;
  logic   in_idle;
  logic   in_wait;
  logic   handshake;

  assign in_idle = (state == IDLE) && !reset;
  assign in_wait = (state == WAIT) && !reset;

  // Pick the side presented to memory this cycle. last_grant only moves on a
  // handshake, so a stalled grant stays on the same side.
  always_comb begin
    grant_data = 1'b0;
    if (bus.data_req && !bus.inst_req)
      grant_data = 1'b1;
    else if (bus.data_req && bus.inst_req)
      grant_data = DATA_PRIO ? 1'b1 : ~last_grant;
  end

  // Request path: pass the granted side through to the shared port.
  always_comb begin
    bus.mem_req   = in_idle && (bus.inst_req || bus.data_req);
    bus.mem_wr    = 1'b0;
    bus.mem_size  = 2'd2;
    bus.mem_addr  = bus.inst_addr;
    bus.mem_wdata = 32'h0;
    if (grant_data) begin
      bus.mem_wr    = bus.data_wr;
      bus.mem_size  = bus.data_size;
      bus.mem_addr  = bus.data_addr;
      bus.mem_wdata = bus.data_wdata;
    end
  end

  assign handshake        = bus.mem_req && bus.mem_addr_ok;
  assign bus.inst_addr_ok = in_idle && !grant_data && bus.mem_addr_ok;
  assign bus.data_addr_ok = in_idle &&  grant_data && bus.mem_addr_ok;

  // Response path: data_ok goes only to the owner, and only while a
  // transaction is outstanding. A stray mem_data_ok in IDLE is dropped.
  assign bus.inst_data_ok = in_wait && !owner && bus.mem_data_ok;
  assign bus.data_data_ok = in_wait &&  owner && bus.mem_data_ok;
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  // Transaction FSM: capture the owner on the address handshake and release it on the data return.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            owner      <= grant_data;
            last_grant <= grant_data;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_data_ok)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter. One instance uses fixed data priority
// and the other uses round-robin. Expected values are hand-computed constants.
module tb_cpu_mem_arbiter;
  logic clk;
  logic reset;
  int   ncmp;
  int   nfail;

  cpu_mem_arbiter_if ia ();
  cpu_mem_arbiter_if ib ();

  cpu_mem_arbiter #(.DATA_PRIO(1'b1)) u_prio (.clk(clk), .reset(reset), .bus(ia));
  cpu_mem_arbiter #(.DATA_PRIO(1'b0)) u_rr   (.clk(clk), .reset(reset), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge. Inputs are then changed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ncmp = 0;
    nfail = 0;
    reset = 1'b1;
    ia.inst_req = 0; ia.inst_addr = 0; ia.data_req = 0; ia.data_wr = 0;
    ia.data_size = 0; ia.data_addr = 0; ia.data_wdata = 0;
    ia.mem_addr_ok = 0; ia.mem_data_ok = 0; ia.mem_rdata = 0;
    ib.inst_req = 0; ib.inst_addr = 0; ib.data_req = 0; ib.data_wr = 0;
    ib.data_size = 0; ib.data_addr = 0; ib.data_wdata = 0;
    ib.mem_addr_ok = 0; ib.mem_data_ok = 0; ib.mem_rdata = 0;
    step();
    step();

    // Reset holds all handshake outputs low even when requests and mem readiness are present
    ia.inst_req = 1; ia.inst_addr = 32'hBFC0_0000; ia.mem_addr_ok = 1; ia.mem_data_ok = 1;
    #1;
    chk("rst_mem_req",    ia.mem_req, 0);
    chk("rst_inst_aok",   ia.inst_addr_ok, 0);
    chk("rst_inst_dok",   ia.inst_data_ok, 0);
    chk("rst_data_dok",   ia.data_data_ok, 0);
    step();
    ia.mem_data_ok = 0;
    reset = 0;

    // Test 1: inst fetch
    #1;
    chk("t1_mem_req",   ia.mem_req, 1);
    chk("t1_mem_addr",  ia.mem_addr, 32'hBFC0_0000);
    chk("t1_mem_wr",    ia.mem_wr, 0);
    chk("t1_mem_size",  ia.mem_size, 2);
    chk("t1_inst_aok",  ia.inst_addr_ok, 1);
    chk("t1_data_aok",  ia.data_addr_ok, 0);
    step();
    ia.inst_req = 0; ia.mem_addr_ok = 0; ia.mem_data_ok = 1; ia.mem_rdata = 32'h3C08_BFAF;
    #1;
    chk("t1_inst_dok",  ia.inst_data_ok, 1);
    chk("t1_inst_rdata", ia.inst_rdata, 32'h3C08_BFAF);
    chk("t1_data_dok",  ia.data_data_ok, 0);
    chk("t1_wait_req",  ia.mem_req, 0);
    step();
    ia.mem_data_ok = 0;

    // Test 2: data has priority over inst on a simultaneous request
    ia.inst_req = 1; ia.inst_addr = 32'hBFC0_0004;
    ia.data_req = 1; ia.data_wr = 1; ia.data_size = 0;
    ia.data_addr = 32'h0000_1000; ia.data_wdata = 32'h0000_00AB; ia.mem_addr_ok = 1;
    #1;
    chk("t2_mem_wr",    ia.mem_wr, 1);
    chk("t2_mem_size",  ia.mem_size, 0);
    chk("t2_mem_addr",  ia.mem_addr, 32'h0000_1000);
    chk("t2_mem_wdata", ia.mem_wdata, 32'h0000_00AB);
    chk("t2_data_aok",  ia.data_addr_ok, 1);
    chk("t2_inst_aok",  ia.inst_addr_ok, 0);
    step();
    ia.data_req = 0; ia.mem_data_ok = 1;
    #1;
    chk("t2_data_dok",  ia.data_data_ok, 1);
    chk("t2_inst_dok",  ia.inst_data_ok, 0);
    chk("t2_wait_iaok", ia.inst_addr_ok, 0);
    step();
    ia.mem_data_ok = 0;
    #1;
    chk("t2_inst_next_aok", ia.inst_addr_ok, 1);
    chk("t2_inst_next_addr", ia.mem_addr, 32'hBFC0_0004);
    chk("t2_inst_next_wr", ia.mem_wr, 0);
    step();

    // Test 4: WAIT (owner inst) with a pending data request and no data return
    ia.inst_req = 0; ia.data_req = 1; ia.data_wr = 0; ia.data_size = 2;
    ia.data_addr = 32'h0000_2000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_mem_req",  ia.mem_req, 0);
      chk("t4_data_aok", ia.data_addr_ok, 0);
      chk("t4_data_dok", ia.data_data_ok, 0);
      chk("t4_inst_dok", ia.inst_data_ok, 0);
      step();
    end
    ia.data_req = 0; ia.mem_data_ok = 1;
    #1;
    chk("t4_inst_dok_end", ia.inst_data_ok, 1);
    step();

    // Test 5: spurious mem_data_ok in IDLE
    ia.mem_data_ok = 1;
    #1;
    chk("t5_inst_dok", ia.inst_data_ok, 0);
    chk("t5_data_dok", ia.data_data_ok, 0);
    step();
    #1;
    chk("t5_inst_dok2", ia.inst_data_ok, 0);
    chk("t5_data_dok2", ia.data_data_ok, 0);
    ia.mem_data_ok = 0;

    // Test 6: reset in WAIT, then a late data return
    ia.inst_req = 1; ia.inst_addr = 32'hBFC0_0008;
    #1;
    chk("t6_inst_aok", ia.inst_addr_ok, 1);
    step();
    ia.inst_req = 0;
    reset = 1;
    #1;
    chk("t6_rst_mem_req", ia.mem_req, 0);
    chk("t6_rst_inst_dok", ia.inst_data_ok, 0);
    step();
    reset = 0; ia.mem_data_ok = 1;
    #1;
    chk("t6_late_inst_dok", ia.inst_data_ok, 0);
    chk("t6_late_data_dok", ia.data_data_ok, 0);
    step();
    ia.mem_data_ok = 0; ia.inst_req = 1; ia.inst_addr = 32'hBFC0_000C;
    #1;
    chk("t6_next_aok",  ia.inst_addr_ok, 1);
    chk("t6_next_addr", ia.mem_addr, 32'hBFC0_000C);
    step();
    ia.inst_req = 0; ia.mem_data_ok = 1;
    #1;
    chk("t6_next_dok",  ia.inst_data_ok, 1);
    step();
    ia.mem_data_ok = 0;

    // Test 3: round-robin. A data-only transaction first makes last_grant=data.
    ib.inst_addr = 32'hBFC0_0100;
    ib.data_req = 1; ib.data_wr = 0; ib.data_size = 2; ib.data_addr = 32'h0000_3000;
    ib.mem_addr_ok = 1;
    #1;
    chk("t3_prime_data_aok", ib.data_addr_ok, 1);
    step();
    ib.inst_req = 1; ib.mem_data_ok = 1;
    #1;
    chk("t3_prime_data_dok", ib.data_data_ok, 1);
    step();
    ib.mem_data_ok = 0; ib.mem_addr_ok = 0;
    // A stalled grant stays on inst while mem_addr_ok is low.
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_stall_req",  ib.mem_req, 1);
      chk("t3_stall_addr", ib.mem_addr, 32'hBFC0_0100);
      chk("t3_stall_iaok", ib.inst_addr_ok, 0);
      step();
    end
    ib.mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      logic exp_d;
      exp_d = i[0];
      #1;
      chk("t3_inst_aok", ib.inst_addr_ok, {31'b0, ~exp_d});
      chk("t3_data_aok", ib.data_addr_ok, {31'b0, exp_d});
      chk("t3_mem_addr", ib.mem_addr, exp_d ? 32'h0000_3000 : 32'hBFC0_0100);
      step();
      ib.mem_data_ok = 1;
      #1;
      chk("t3_inst_dok", ib.inst_data_ok, {31'b0, ~exp_d});
      chk("t3_data_dok", ib.data_data_ok, {31'b0, exp_d});
      step();
      ib.mem_data_ok = 0;
    end
    ib.inst_req = 0; ib.data_req = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end of run, expected end of run before 100000 ns");
    $fatal(1, "timeout");
  end
endmodule
